// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: bundles the two requester ports and the RAM port of the
// data-RAM arbiter.
//   m0_*  : MEM-stage port (read/write, byte lanes, high priority)
//   m1_*  : instruction-fetch port (read-only)
//   ram_* : single-port RAM; ram_rdata is combinational from ram_addr
// slave  modport: the arbiter side.
// master modport: requesters plus RAM model (the environment side).
interface dram_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [SW-1:0] m0_sel;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m0_stall;

  logic          m1_req;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic          m1_stall;

  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [SW-1:0] ram_sel;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    output m0_rdata, m0_ack, m0_stall,
    input  m1_req, m1_addr,
    output m1_rdata, m1_ack, m1_stall,
    output ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_sel, m0_wdata,
    input  m0_rdata, m0_ack, m0_stall,
    output m1_req, m1_addr,
    input  m1_rdata, m1_ack, m1_stall,
    input  ram_ce, ram_we, ram_addr, ram_sel, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port byte-lane data RAM between the MEM
// stage (port 0, priority) and instruction fetch (port 1, read-only).
// Each access runs IDLE -> ACCESS (one RAM cycle) -> RESP (one-cycle ack).
// A starvation counter lets port 1 through after STARVE_LIMIT consecutive
// port-0 wins while it waits (0 disables that and gives fixed priority).
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : dram_arbiter_if.slave (m0_*, m1_*, ram_* signals)
// Outputs are registered except m*_stall and ram_ce/ram_we, which are
// combinational (stall from req/ack; RAM strobes gated by rst).
module dram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dram_arbiter_if.slave  bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic          LIMIT_EN = (STARVE_LIMIT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [SW-1:0] sel;
    logic [DW-1:0] wdata;
  } acc_t;

  state_t        r_state, w_state_nxt;
  acc_t          r_acc, w_acc_nxt;
  logic          r_grant, w_grant_nxt;      // 0 = port 0, 1 = port 1
  logic [CW-1:0] r_starve, w_starve_nxt;
  logic          r_m0_ack, w_m0_ack_nxt;
  logic          r_m1_ack, w_m1_ack_nxt;
  logic [DW-1:0] r_m0_rdata, r_m1_rdata;
  logic          w_any_req;
  logic          w_pick1;
  logic          w_grant_p1;

  assign w_any_req = bus.m0_req | bus.m1_req;
  // Port 1 wins when alone, or when it has waited through LIMIT port-0 grants.
  assign w_pick1   = bus.m1_req & (~bus.m0_req | (LIMIT_EN & (r_starve == LIMIT)));
  assign w_grant_p1 = (r_state == IDLE) & w_pick1;

  // Next-state, request latch, ack generation
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_grant_nxt  = r_grant;
    w_m0_ack_nxt = 1'b0;
    w_m1_ack_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ACCESS;
          w_grant_nxt = w_pick1;
          if (w_pick1) begin
            w_acc_nxt = '{we: 1'b0, addr: bus.m1_addr, sel: '1, wdata: '0};
          end else begin
            w_acc_nxt = '{we: bus.m0_we, addr: bus.m0_addr, sel: bus.m0_sel,
                          wdata: bus.m0_wdata};
          end
        end
      end
      ACCESS: begin
        w_state_nxt  = RESP;
        w_m0_ack_nxt = ~r_grant;
        w_m1_ack_nxt = r_grant;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Starvation counter: counts port-0 wins while port 1 is waiting
  always_comb begin
    w_starve_nxt = r_starve;
    if (!bus.m1_req || w_grant_p1) begin
      w_starve_nxt = '0;
    end else if ((r_state == IDLE) && bus.m0_req && (r_starve != CNT_MAX)) begin
      w_starve_nxt = r_starve + CW'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_grant    <= 1'b0;
      r_starve   <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_grant  <= w_grant_nxt;
      r_starve <= w_starve_nxt;
      r_m0_ack <= w_m0_ack_nxt;
      r_m1_ack <= w_m1_ack_nxt;
      // Read data is captured at the end of the RAM cycle, also on writes.
      if (r_state == ACCESS) begin
        if (r_grant) r_m1_rdata <= bus.ram_rdata;
        else         r_m0_rdata <= bus.ram_rdata;
      end
    end
  end

  // Reset gates the strobes so an in-flight write never lands.
  assign bus.ram_ce    = (r_state == ACCESS) & ~rst;
  assign bus.ram_we    = (r_state == ACCESS) & r_acc.we & ~rst;
  assign bus.ram_addr  = r_acc.addr;
  assign bus.ram_sel   = r_acc.sel;
  assign bus.ram_wdata = r_acc.wdata;

  assign bus.m0_ack   = r_m0_ack;
  assign bus.m0_rdata = r_m0_rdata;
  assign bus.m0_stall = bus.m0_req & ~r_m0_ack;
  assign bus.m1_ack   = r_m1_ack;
  assign bus.m1_rdata = r_m1_rdata;
  assign bus.m1_stall = bus.m1_req & ~r_m1_ack;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model (grant times, per-port expected data,
// word-array memory image). A second instance with STARVE_LIMIT=0 checks
// pure fixed priority under contention.
module tb_dram_arbiter;

  localparam int LIMIT_A = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_arbiter_if u_if_a ();
  dram_arbiter_if u_if_b ();

  dram_arbiter #(.STARVE_LIMIT(LIMIT_A)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if_a)
  );

  dram_arbiter #(.STARVE_LIMIT(0)) u_dut_fp (
    .clk (clk),
    .rst (rst),
    .bus (u_if_b)
  );

  // RAM behind instance A: combinational read, byte-lane write on the edge
  logic [31:0] mem_a [256];
  assign u_if_a.ram_rdata = mem_a[u_if_a.ram_addr[9:2]];
  always @(posedge clk) begin
    if (u_if_a.ram_ce && u_if_a.ram_we)
      for (int b = 0; b < 4; b++)
        if (u_if_a.ram_sel[b]) mem_a[u_if_a.ram_addr[9:2]][8*b +: 8] <= u_if_a.ram_wdata[8*b +: 8];
  end
  assign u_if_b.ram_rdata = 32'h0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  int          cyc       = 0;    // number of rising edges seen
  int          free_from = 0;    // first period in which the arbiter is idle
  int          acc_at    = -10;  // period of the RAM access
  int          resp_at   = -10;  // period of the ack
  int          starve    = 0;
  logic        t_port, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_sel;
  logic [31:0] ref_mem [256];
  logic [31:0] exp_rd  [2];
  bit          rd_known [2];

  always @(posedge clk) begin
    bit   granted;
    logic g;
    cyc = cyc + 1;
    if (rst) begin
      free_from = cyc;
      acc_at    = -10;
      resp_at   = -10;
      starve    = 0;
      exp_rd[0] = 32'h0;  exp_rd[1] = 32'h0;
      rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    end else begin
      if (acc_at == cyc - 1) begin
        exp_rd[t_port]   = ref_mem[t_addr[9:2]];
        rd_known[t_port] = !t_we;
        if (t_we)
          for (int b = 0; b < 4; b++)
            if (t_sel[b]) ref_mem[t_addr[9:2]][8*b +: 8] = t_wdata[8*b +: 8];
        resp_at = cyc;
      end
      granted = 1'b0;
      g       = 1'b0;
      if (cyc - 1 >= free_from && (u_if_a.m0_req || u_if_a.m1_req)) begin
        granted = 1'b1;
        if (u_if_a.m0_req && u_if_a.m1_req) g = (LIMIT_A != 0) && (starve == LIMIT_A);
        else                                g = u_if_a.m1_req;
        t_port = g;
        if (g) begin
          t_we = 1'b0; t_addr = u_if_a.m1_addr; t_sel = 4'hF; t_wdata = 32'h0;
        end else begin
          t_we = u_if_a.m0_we; t_addr = u_if_a.m0_addr;
          t_sel = u_if_a.m0_sel; t_wdata = u_if_a.m0_wdata;
        end
        acc_at    = cyc;
        free_from = cyc + 2;
      end
      if (!u_if_a.m1_req)      starve = 0;
      else if (granted && g)   starve = 0;
      else if (granted)        starve = (starve < 15) ? starve + 1 : 15;
    end
  end

  // Compare every observable output of instance A against the model
  task automatic check_cycle();
    bit ce_e, a0_e, a1_e;
    ce_e = (cyc == acc_at) && !rst;
    a0_e = (cyc == resp_at) && (t_port == 1'b0);
    a1_e = (cyc == resp_at) && (t_port == 1'b1);
    check_eq("ram_ce", 32'(u_if_a.ram_ce), 32'(ce_e));
    check_eq("ram_we", 32'(u_if_a.ram_we), 32'(ce_e && t_we));
    if (ce_e) begin
      check_eq("ram_addr", u_if_a.ram_addr, t_addr);
      check_eq("ram_sel", 32'(u_if_a.ram_sel), 32'(t_sel));
      if (t_we) check_eq("ram_wdata", u_if_a.ram_wdata, t_wdata);
    end
    check_eq("m0_ack", 32'(u_if_a.m0_ack), 32'(a0_e));
    check_eq("m1_ack", 32'(u_if_a.m1_ack), 32'(a1_e));
    check_eq("m0_stall", 32'(u_if_a.m0_stall), 32'(u_if_a.m0_req && !a0_e));
    check_eq("m1_stall", 32'(u_if_a.m1_stall), 32'(u_if_a.m1_req && !a1_e));
    if (rd_known[0]) check_eq("m0_rdata", u_if_a.m0_rdata, exp_rd[0]);
    if (rd_known[1]) check_eq("m1_rdata", u_if_a.m1_rdata, exp_rd[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_cycle();
  endtask

  // One port-0 transaction from an idle arbiter; returns data, ack latency
  // and the cycle in which the RAM strobe was seen. Ends with one idle cycle.
  task automatic m0_do(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat,
                       output int ce_at);
    u_if_a.m0_req = 1'b1; u_if_a.m0_we = we; u_if_a.m0_addr = addr;
    u_if_a.m0_sel = sel;  u_if_a.m0_wdata = wd;
    lat = -1; ce_at = -1; rd = 32'h0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      cycle();
      if (u_if_a.ram_ce && ce_at < 0) ce_at = i;
      if (u_if_a.m0_ack) begin lat = i; rd = u_if_a.m0_rdata; end
    end
    u_if_a.m0_req = 1'b0;
    cycle();
  endtask

  task automatic m1_do(input logic [31:0] addr, output logic [31:0] rd, output int lat);
    u_if_a.m1_req = 1'b1; u_if_a.m1_addr = addr;
    lat = -1; rd = 32'h0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      cycle();
      if (u_if_a.m1_ack) begin lat = i; rd = u_if_a.m1_rdata; end
    end
    u_if_a.m1_req = 1'b0;
    cycle();
  endtask

  task automatic new_m0();
    u_if_a.m0_req   = 1'b1;
    u_if_a.m0_we    = 1'($urandom_range(0, 1));
    u_if_a.m0_addr  = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
    u_if_a.m0_sel   = 4'($urandom);
    u_if_a.m0_wdata = $urandom;
  endtask

  task automatic new_m1();
    u_if_a.m1_req  = 1'b1;
    u_if_a.m1_addr = {22'h0, 8'($urandom_range(0, 15)), 2'b00};
  endtask

  initial begin
    logic [31:0] rd;
    int lat, ce_at, m0_cnt, m1_at, b_m0, b_m1;

    for (int i = 0; i < 256; i++) begin mem_a[i] = 32'h0; ref_mem[i] = 32'h0; end
    u_if_a.m0_req = 0; u_if_a.m0_we = 0; u_if_a.m0_addr = 0; u_if_a.m0_sel = 0;
    u_if_a.m0_wdata = 0; u_if_a.m1_req = 0; u_if_a.m1_addr = 0;
    u_if_b.m0_req = 0; u_if_b.m0_we = 0; u_if_b.m0_addr = 0; u_if_b.m0_sel = 0;
    u_if_b.m0_wdata = 0; u_if_b.m1_req = 0; u_if_b.m1_addr = 0;

    // Reset, then idle
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // Port-0 write then read-back
    m0_do(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, rd, lat, ce_at);
    check_eq("wr_ce_at", 32'(ce_at), 32'd1);
    check_eq("wr_lat", 32'(lat), 32'd2);
    m0_do(1'b0, 32'h100, 4'hF, 32'h0, rd, lat, ce_at);
    check_eq("rd_lat", 32'(lat), 32'd2);
    check_eq("rd_data", rd, 32'hDEADBEEF);

    // Byte-lane merge, observed through port 1
    m0_do(1'b1, 32'h200, 4'hF, 32'h11223344, rd, lat, ce_at);
    m0_do(1'b1, 32'h200, 4'b0100, 32'h00AA0000, rd, lat, ce_at);
    m1_do(32'h200, rd, lat);
    check_eq("lane_lat", 32'(lat), 32'd2);
    check_eq("lane_data", rd, 32'h11AA3344);

    // Contention: A (limit 4) lets port 1 in after 4 port-0 grants,
    // B (limit 0) never does while port 0 keeps requesting.
    u_if_a.m0_req = 1'b1; u_if_a.m0_we = 1'b0; u_if_a.m0_addr = 32'h100;
    u_if_a.m1_req = 1'b1; u_if_a.m1_addr = 32'h200;
    u_if_b.m0_req = 1'b1; u_if_b.m0_addr = 32'h100;
    u_if_b.m1_req = 1'b1; u_if_b.m1_addr = 32'h200;
    m0_cnt = 0; m1_at = -1; b_m0 = 0; b_m1 = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (u_if_a.m0_ack) begin
        if (m1_at < 0) m0_cnt++;
        u_if_a.m0_addr = {22'h0, 8'(i), 2'b00};
      end
      if (u_if_a.m1_ack && m1_at < 0) begin m1_at = i; u_if_a.m1_req = 1'b0; end
      if (u_if_b.m0_ack) b_m0++;
      if (u_if_b.m1_ack) b_m1++;
    end
    check_eq("cont_m0_before_m1", 32'(m0_cnt), 32'd4);
    check_eq("cont_m1_ack_cycle", 32'(m1_at), 32'd14);
    check_eq("fixprio_m1_acks", 32'(b_m1), 32'd0);
    check_eq("fixprio_m0_acks", 32'(b_m0), 32'd7);
    u_if_a.m0_req = 1'b0; u_if_a.m1_req = 1'b0;
    u_if_b.m0_req = 1'b0; u_if_b.m1_req = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Reset during the ACCESS cycle of a write suppresses it
    m0_do(1'b1, 32'h300, 4'hF, 32'h12345678, rd, lat, ce_at);
    u_if_a.m0_req = 1'b1; u_if_a.m0_we = 1'b1; u_if_a.m0_addr = 32'h300;
    u_if_a.m0_sel = 4'hF; u_if_a.m0_wdata = 32'h00000055;
    cycle();
    check_eq("mid_ce_pre_rst", 32'(u_if_a.ram_ce), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_we", 32'(u_if_a.ram_we), 32'd0);
    check_eq("mid_rst_ce", 32'(u_if_a.ram_ce), 32'd0);
    u_if_a.m0_req = 1'b0;
    cycle();
    check_eq("mid_rst_noack", 32'(u_if_a.m0_ack), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("mid_rst_noack_late", 32'(u_if_a.m0_ack), 32'd0);
    end
    m0_do(1'b0, 32'h300, 4'hF, 32'h0, rd, lat, ce_at);
    check_eq("mid_rst_old_data", rd, 32'h12345678);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 4000; n++) begin
      cycle();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 199) == 0) rst = 1'b1;
      if (u_if_a.m0_req) begin
        if (u_if_a.m0_ack) begin
          if ($urandom_range(0, 3) != 0) new_m0();
          else u_if_a.m0_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) new_m0();
      if (u_if_a.m1_req) begin
        if (u_if_a.m1_ack) begin
          if ($urandom_range(0, 1) != 0) new_m1();
          else u_if_a.m1_req = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) new_m1();
    end
    rst = 1'b0;
    u_if_a.m0_req = 1'b0; u_if_a.m1_req = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
